// File: rtl/cpu_pkg.sv
// Shared CPU types: branch condition codes, condition-flag struct and
// the branch-resolution FSM state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NE     = 3'b000,
    BR_EQ     = 3'b001,
    BR_GT     = 3'b010,
    BR_LT     = 3'b011,
    BR_GE     = 3'b100,
    BR_LE     = 3'b101,
    BR_OVF    = 3'b110,
    BR_ALWAYS = 3'b111
  } br_cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flag_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational branch-condition evaluator; shared with the decode-stage
// predictor so both agree on what each condition code means.
module cond_eval
  import cpu_pkg::*;
(
  input  br_cond_t cond,
  input  flag_t    f,
  output logic     taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_NE:     taken = ~f.z;
      BR_EQ:     taken = f.z;
      BR_GT:     taken = ~f.z & ~f.n;
      BR_LT:     taken = f.n;
      BR_GE:     taken = ~f.n;
      BR_LE:     taken = f.n | f.z;
      BR_OVF:    taken = f.v;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// ALU-result consumer: holds architectural N/Z/V flags, counts in-flight
// flag-setting ops and resolves conditional-branch queries from decode.
module branch_flag_unit
  import cpu_pkg::*;
#(
  parameter  int MAX_PENDING = 3,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_issue,
  input  logic             ALU_done,
  input  logic             N,
  input  logic             Z,
  input  logic             V,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic             br_ready,
  output logic             res_valid,
  output logic             res_taken,
  input  logic             res_ready,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] pending,
  output logic             err,
  output br_state_t        state_dbg
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

  // Handshakes: a query transfers on a cycle where br_valid && br_ready;
  // a resolution transfers on a cycle where res_valid && res_ready.
  // res_valid/res_taken stay stable until that transfer; a flush drops both.

  flag_t            flags_q, flags_next;
  logic [CNT_W-1:0] pend_q, pend_next;
  logic             err_q, err_next;

  br_state_t        state, state_next;
  br_cond_t         cond_q, cond_next, eval_cond;
  logic             taken_q, taken_next;
  logic             eval_taken;

  // Counter and flag register next-state; flush overrides counting.
  always_comb begin
    pend_next  = pend_q;
    err_next   = err_q;
    flags_next = ALU_done ? flag_t'({N, Z, V}) : flags_q;
    if (flush) begin
      pend_next = '0;
    end else if (flag_issue && !ALU_done) begin
      if (pend_q == PEND_MAX) err_next = 1'b1;
      else                    pend_next = pend_q + CNT_W'(1);
    end else if (ALU_done && !flag_issue) begin
      if (pend_q == '0) err_next = 1'b1;
      else              pend_next = pend_q - CNT_W'(1);
    end
  end

  // In IDLE the live request is evaluated; in WAIT the captured one.
  assign eval_cond = (state == ST_IDLE) ? br_cond_t'(br_cond) : cond_q;

  cond_eval u_cond_eval (
    .cond  (eval_cond),
    .f     (flags_next),
    .taken (eval_taken)
  );

  always_comb begin
    state_next = state;
    cond_next  = cond_q;
    taken_next = taken_q;
    if (flush) begin
      state_next = ST_IDLE;
      taken_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (br_valid) begin
            cond_next = br_cond_t'(br_cond);
            if (pend_next == '0) begin
              taken_next = eval_taken;
              state_next = ST_RESP;
            end else begin
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (pend_next == '0) begin
            taken_next = eval_taken;
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cond_q  <= BR_NE;
      taken_q <= 1'b0;
      flags_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cond_q  <= cond_next;
      taken_q <= taken_next;
      flags_q <= flags_next;
      pend_q  <= pend_next;
      err_q   <= err_next;
    end
  end

  assign br_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_RESP);
  assign res_taken = taken_q;
  assign flags     = flags_q;
  assign pending   = pend_q;
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed scenarios plus a
// randomized run compared against a behavioural model of the unit.
module tb_branch_flag_unit;
  import cpu_pkg::*;

  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag_issue = 1'b0, alu_done = 1'b0;
  logic       n = 1'b0, z = 1'b0, v = 1'b0;
  logic       flush = 1'b0, br_valid = 1'b0, res_ready = 1'b0;
  logic [2:0] br_cond = 3'b000;
  logic       br_ready, res_valid, res_taken, err;
  logic [2:0] flags;
  logic [1:0] pending;
  br_state_t  state_dbg;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int       m_pend;
  bit [2:0] m_flags;
  bit       m_err;
  int       m_phase;   // 0 no query, 1 query waiting for flags, 2 answer held
  int       m_cond;
  bit       m_taken;

  branch_flag_unit #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .ALU_done(alu_done),
    .N(n), .Z(z), .V(v), .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(br_ready), .res_valid(res_valid), .res_taken(res_taken),
    .res_ready(res_ready), .flags(flags), .pending(pending), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Condition table, flags given as {N,Z,V}
  function automatic bit ref_taken(input int c, input bit [2:0] f);
    bit fn, fz, fv;
    fn = f[2]; fz = f[1]; fv = f[0];
    case (c)
      0: return !fz;
      1: return fz;
      2: return !fz && !fn;
      3: return fn;
      4: return !fn;
      5: return fn || fz;
      6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_flags = 3'b000; m_err = 0; m_phase = 0; m_cond = 0; m_taken = 0;
  endtask

  task automatic model_step();
    int pn;
    bit [2:0] fn;
    pn = m_pend;
    if (flush) pn = 0;
    else if (flag_issue && !alu_done) begin
      if (m_pend == MAXP) m_err = 1; else pn = m_pend + 1;
    end else if (alu_done && !flag_issue) begin
      if (m_pend == 0) m_err = 1; else pn = m_pend - 1;
    end
    fn = alu_done ? {n, z, v} : m_flags;
    if (flush) begin
      m_phase = 0; m_taken = 0;
    end else if (m_phase == 0 && br_valid) begin
      m_cond = int'(br_cond);
      if (pn == 0) begin m_taken = ref_taken(m_cond, fn); m_phase = 2; end
      else m_phase = 1;
    end else if (m_phase == 1 && pn == 0) begin
      m_taken = ref_taken(m_cond, fn); m_phase = 2;
    end else if (m_phase == 2 && res_ready) begin
      m_phase = 0;
    end
    m_pend = pn;
    m_flags = fn;
  endtask

  task automatic idle_inputs();
    flag_issue = 0; alu_done = 0; n = 0; z = 0; v = 0;
    flush = 0; br_valid = 0; br_cond = 3'b000; res_ready = 0;
  endtask

  // One clock: model advances with the inputs seen at the edge, DUT sampled 1ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    checks++;
    if ({br_ready, res_valid, res_taken, flags, pending, err} !== {1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b val=%b tk=%b fl=%b pend=%0d err=%b expected 1 0 0 000 0 0",
               br_ready, res_valid, res_taken, flags, pending, err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    alu_done = 1; n = 0; z = 1; v = 0;
    tick();
    idle_inputs();
    checks++;
    if (flags !== 3'b010 || err !== 1'b1) begin
      failures++;
      $display("FAIL basic_flags got fl=%b err=%b expected 010 1", flags, err);
    end
    br_valid = 1; br_cond = 3'b001;
    tick();
    idle_inputs();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1 || br_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_eq_resolve got val=%b tk=%b rdy=%b expected 1 1 0", res_valid, res_taken, br_ready);
    end
    res_ready = 1;
    tick();
    idle_inputs();
    checks++;
    if (res_valid !== 1'b0 || br_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_handshake got val=%b rdy=%b expected 0 1", res_valid, br_ready);
    end
  endtask

  task automatic test_wait_and_hold();
    do_reset();
    flag_issue = 1;
    tick(); tick();
    idle_inputs();
    br_valid = 1; br_cond = 3'b011;
    tick();
    idle_inputs();
    checks++;
    if (br_ready !== 1'b0 || res_valid !== 1'b0 || pending !== 2'd2) begin
      failures++;
      $display("FAIL wait_entered got rdy=%b val=%b pend=%0d expected 0 0 2", br_ready, res_valid, pending);
    end
    alu_done = 1; n = 0;
    tick();
    idle_inputs();
    checks++;
    if (res_valid !== 1'b0 || pending !== 2'd1) begin
      failures++;
      $display("FAIL wait_after_done1 got val=%b pend=%0d expected 0 1", res_valid, pending);
    end
    alu_done = 1; n = 1;
    tick();
    idle_inputs();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1 || pending !== 2'd0) begin
      failures++;
      $display("FAIL wait_resolve got val=%b tk=%b pend=%0d expected 1 1 0", res_valid, res_taken, pending);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_taken !== 1'b1 || br_ready !== 1'b0) begin
        failures++;
        $display("FAIL resp_hold cycle %0d got val=%b tk=%b rdy=%b expected 1 1 0", i, res_valid, res_taken, br_ready);
      end
    end
    res_ready = 1;
    tick();
    idle_inputs();
    checks++;
    if (res_valid !== 1'b0 || br_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_release got val=%b rdy=%b expected 0 1", res_valid, br_ready);
    end
  endtask

  task automatic test_counter();
    do_reset();
    flag_issue = 1;
    tick(); tick();
    alu_done = 1;
    tick();
    checks++;
    if (pending !== 2'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL cnt_issue_done got pend=%0d err=%b expected 2 0", pending, err);
    end
    alu_done = 0;
    tick(); tick();
    checks++;
    if (pending !== 2'd3 || err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_overflow got pend=%0d err=%b expected 3 1", pending, err);
    end
    idle_inputs();
    alu_done = 1;
    repeat (3) tick();
    idle_inputs();
    tick();
    checks++;
    if (pending !== 2'd0 || err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_err_sticky got pend=%0d err=%b expected 0 1", pending, err);
    end
  endtask

  task automatic test_flush_and_async_reset();
    do_reset();
    flag_issue = 1;
    tick();
    flag_issue = 0; alu_done = 1; n = 1; z = 0; v = 1;
    tick();
    idle_inputs();
    flag_issue = 1;
    tick(); tick();
    idle_inputs();
    br_valid = 1; br_cond = 3'b111;
    tick();
    idle_inputs();
    flush = 1;
    tick();
    idle_inputs();
    checks++;
    if (pending !== 2'd0 || br_ready !== 1'b1 || res_valid !== 1'b0 || flags !== 3'b101 || err !== 1'b0) begin
      failures++;
      $display("FAIL flush_wait got pend=%0d rdy=%b val=%b fl=%b err=%b expected 0 1 0 101 0",
               pending, br_ready, res_valid, flags, err);
    end
    tick(); tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_resp got val=%b expected 0", res_valid);
    end
    br_valid = 1; br_cond = 3'b100;
    tick();
    idle_inputs();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({br_ready, res_valid, res_taken, flags, pending, err} !== {1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_resp got rdy=%b val=%b tk=%b fl=%b pend=%0d err=%b expected 1 0 0 000 0 0",
               br_ready, res_valid, res_taken, flags, pending, err);
    end
    model_reset();
    #1 rst_n = 1;
  endtask

  // Each query is accepted in the same cycle as the completing done (forwarding)
  task automatic test_sweep();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        bit [2:0] fv;
        bit exp_tk;
        fv = 3'(f);
        exp_tk = ref_taken(c, fv);
        idle_inputs();
        flag_issue = 1;
        tick();
        idle_inputs();
        alu_done = 1; {n, z, v} = fv;
        br_valid = 1; br_cond = 3'(c);
        tick();
        idle_inputs();
        checks++;
        if (res_valid !== 1'b1 || res_taken !== exp_tk || flags !== fv) begin
          failures++;
          $display("FAIL sweep cond=%0d flags=%b got val=%b tk=%b fl=%b expected 1 %b %b",
                   c, fv, res_valid, res_taken, flags, exp_tk, fv);
        end
        res_ready = 1;
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      flag_issue = ($urandom_range(0, 99) < 35);
      alu_done   = ($urandom_range(0, 99) < 30);
      {n, z, v}  = 3'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 99) < 3);
      br_valid   = ($urandom_range(0, 99) < 40);
      br_cond    = 3'($urandom_range(0, 7));
      res_ready  = ($urandom_range(0, 99) < 50);
      tick();
      checks++;
      if (pending !== 2'(m_pend) || flags !== m_flags || err !== m_err ||
          br_ready !== (m_phase == 0) || res_valid !== (m_phase == 2) ||
          (m_phase == 2 && res_taken !== m_taken)) begin
        failures++;
        $display("FAIL random cycle %0d got pend=%0d fl=%b err=%b rdy=%b val=%b tk=%b expected %0d %b %b %b %b %b",
                 i, pending, flags, err, br_ready, res_valid, res_taken,
                 m_pend, m_flags, m_err, (m_phase == 0), (m_phase == 2), m_taken);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wait_and_hold();
    test_counter();
    test_flush_and_async_reset();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Consumer-side endpoint of the ALU result interface. Latches the N/Z/V condition flags whenever the ALU reports `ALU_done`, and tracks how many flag-setting operations are still in flight. Resolves conditional-branch queries from decode against the architectural flags using a valid/ready request and a held response. Sits between the ALU and the fetch/PC-select logic.

## Interface
- `MAX_PENDING`, default 3: maximum in-flight flag-setting ops tracked; counter width `CNT_W = $clog2(MAX_PENDING+1)`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flag_issue` in 1: one flag-setting ALU op issued this cycle.
- `ALU_done` in 1: ALU completed a flag-setting op; `N`/`Z`/`V` valid this cycle.
- `N`, `Z`, `V` in 1 each: ALU flags, sampled only when `ALU_done`=1.
- `flush` in 1: pipeline flush.
- `br_valid` in 1: branch query request.
- `br_cond` in 3: condition code (see Operation).
- `br_ready` out 1: unit can accept a query.
- `res_valid` out 1: resolution available.
- `res_taken` out 1: branch taken; meaningful only while `res_valid`=1.
- `res_ready` in 1: consumer accepts the resolution.
- `flags` out 3: architectural {N,Z,V}.
- `pending` out CNT_W: in-flight flag-setting op count.
- `err` out 1: sticky; set on counter overflow or underflow.

## Operation
- Flag register: on `ALU_done`=1, `flags` <= {N,Z,V}. Otherwise hold. Shift ops (which do not assert done) leave the flags untouched.
- Pending counter: +1 on `flag_issue`, -1 on `ALU_done`, unchanged when both are asserted. `flag_issue` at `MAX_PENDING` (without done) is ignored and sets `err`. `ALU_done` at 0 (without issue) is ignored and sets `err`.
- `pend_next` is the counter's next value. `flags_next` is the flag register's next value, which includes a same-cycle done (forwarding).
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: !N
  - 101 LE: N|Z
  - 110 OVF: V
  - 111 ALWAYS: 1
- FSM states: IDLE, WAIT, RESP.
- IDLE: `br_ready`=1. On `br_valid`, capture `br_cond`:
  - if `pend_next`==0, register `res_taken` = eval(cond, `flags_next`) and go to RESP;
  - otherwise go to WAIT.
- WAIT: `br_ready`=0. When `pend_next`==0, evaluate using `flags_next` and go to RESP.
- RESP: `br_ready`=0, `res_valid`=1, `res_taken` held stable. On `res_ready`, go to IDLE.
- A `flag_issue` in the same cycle as query acceptance counts as older; the branch waits for it.
- flush (highest priority):
  - pending <= 0;
  - FSM <= IDLE; any captured query or resolution is dropped;
  - `flags` are retained, except that a same-cycle `ALU_done` still updates them;
  - `err` is unaffected;
  - a `br_valid` in the flush cycle is not accepted.
- Reset (asynchronous, any state, mid-WAIT/RESP included): FSM=IDLE, `br_ready`=1, `res_valid`=0, `res_taken`=0, `flags`=000, `pending`=0, `err`=0.

## Timing
- Best case: query accepted at edge T, `res_valid`=1 in the cycle after T (1-cycle latency).
- Done-forwarded case: query accepted with `pending`=1 and `ALU_done` in the same cycle also yields 1-cycle latency, evaluated with the new flags.
- WAIT exits at the edge where the count reaches 0. `res_valid` follows in the next cycle.
- `res_valid` stays high until `res_ready`. The next query can be accepted no earlier than the cycle after the `res_ready` handshake.
- `flags`, `pending`, `err`, `res_*` are registered. `br_ready` is decoded from state only, with no input-to-output combinational path.

## Structure
- Shared package `cpu_pkg`: `br_cond_t` enum (the 8 codes above), `flag_t` struct {n,z,v}, FSM state enum.
- One natural sub-module, `cond_eval`: a pure combinational (cond, flag_t) -> taken function, reused by the decode-stage predictor.
- Remaining logic (counter, flag register, FSM) lives in the top module.

## Test plan
- Reset, then `ALU_done` with N=0,Z=1,V=0, then query EQ with pending 0 -> `res_valid` 1 cycle later, `res_taken`=1; flags=010.
- Issue 2 ops, then query LT: unit sits in WAIT. Done #1 with N=0, then done #2 with N=1 -> resolution 1 cycle after done #2, `res_taken`=1.
- Resolution held with `res_ready`=0 for 5 cycles -> `res_valid` and `res_taken` stable, `br_ready`=0. `res_ready`=1 -> IDLE next cycle.
- `flag_issue` and `ALU_done` in the same cycle at pending=2 -> pending stays 2. Four issues with `MAX_PENDING`=3 -> pending=3, `err`=1 and sticky.
- Flush during WAIT with pending=2 -> pending=0, IDLE, no `res_valid`, flags unchanged. `rst_n` low during RESP -> all outputs at reset values immediately.
- Sweep all 8 conditions against all 8 flag combinations; compare `res_taken` with the condition table above.
